acc_seq_ctrl: RTL and testbench

Phase sequencer for the matrix accelerator datapath. It takes the start pulse from the clock-gate block and steps the X buffer through load, then the ALU and A ROM through `ACC_N` accumulate passes of `SHIFT_N` shift steps each, waiting for each write-back. It then raises a completion pulse. It also drives the APB `pready` stall so the bus is held while the datapath is computing.

---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_seq_ctrl_if.sv | 51 +++++
 rtl/acc_seq_wdt.sv | 34 +++
 rtl/acc_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the matrix accelerator datapath.
// Holds the sequencer state encoding, the default shift/accumulate/ROM
// geometry used by the X buffer, ALU, A ROM and sequencer, and a helper
// that sizes counters (minimum 1 bit).
package acc_pkg;

  localparam int unsigned SHIFT_N_DEF    = 4;
  localparam int unsigned ACC_N_DEF      = 4;
  localparam int unsigned ROM_AW_DEF     = 4;
  localparam int unsigned WDT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_DONE    = 3'd4
  } acc_state_e;

  // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// acc_seq_ctrl_if: handshake/control bundle between the phase sequencer and
// the accelerator datapath (X buffer, ALU, A ROM, APB ready).
//   master : sequencer side  (drives load_en, ALU_en, counters, rom_addr,
//            acc_finish, pready, busy and, with ACC_SEQ_WDT_EN, wdt_err)
//   slave  : datapath side   (drives start_in, load_done, cal_finish)
// Optional feature macro: ACC_SEQ_WDT_EN adds the wdt_err signal.
interface acc_seq_ctrl_if
  import acc_pkg::*;
#(
  parameter int unsigned SHIFT_N = SHIFT_N_DEF,
  parameter int unsigned ACC_N   = ACC_N_DEF,
  parameter int unsigned ROM_AW  = ROM_AW_DEF
);

  localparam int unsigned SW = cnt_w(SHIFT_N);
  localparam int unsigned AW = cnt_w(ACC_N);

  logic              start_in;
  logic              load_done;
  logic              cal_finish;
  logic              load_en;
  logic              ALU_en;
  logic [SW-1:0]     shift_counter;
  logic [AW-1:0]     acc_counter;
  logic [ROM_AW-1:0] rom_addr;
  logic              acc_finish;
  logic              pready;
  logic              busy;
`ifdef ACC_SEQ_WDT_EN
  logic              wdt_err;
`endif

  modport master (
    input  start_in, load_done, cal_finish,
    output load_en, ALU_en, shift_counter, acc_counter, rom_addr,
           acc_finish, pready, busy
`ifdef ACC_SEQ_WDT_EN
    , output wdt_err
`endif
  );

  modport slave (
    output start_in, load_done, cal_finish,
    input  load_en, ALU_en, shift_counter, acc_counter, rom_addr,
           acc_finish, pready, busy
`ifdef ACC_SEQ_WDT_EN
    , input wdt_err
`endif
  );

endinterface

// File: rtl/acc_seq_wdt.sv
// acc_seq_wdt: write-back watchdog counter for the phase sequencer.
// Counts cycles while en_i is high and clears whenever en_i is low.
//   clk, rst    : clock, synchronous active-high reset
//   en_i        : sequencer is waiting for a write-back
//   expire_c_o  : combinational; high on the cycle whose edge would bring
//                 the count to WDT_CYCLES
// Only instantiated when ACC_SEQ_WDT_EN is defined.
module acc_seq_wdt
  import acc_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CW = $clog2(WDT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expire_c_o = en_i && (cnt_q == CW'(WDT_CYCLES - 1));

  // Count while waiting; leaving the wait state clears the count.
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q <= '0;
    end else if (!expire_c_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: phase sequencer for the matrix accelerator datapath.
// IDLE -> LOAD (X buffer fill) -> ACC_N x { COMPUTE (SHIFT_N ALU steps)
// -> WAIT_WB (write-back) } -> DONE (acc_finish pulse) -> IDLE.
// pready is held low while computing to stall the APB bus.
//   clk, rst : gated accelerator clock, synchronous active-high reset
//   bus      : acc_seq_ctrl_if.master (start_in, load_done, cal_finish in;
//              load_en, ALU_en, shift_counter, acc_counter, rom_addr,
//              acc_finish, pready, busy[, wdt_err] out, all registered)
// Optional feature macro: ACC_SEQ_WDT_EN enables the write-back watchdog.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned SHIFT_N    = SHIFT_N_DEF,
  parameter int unsigned ACC_N      = ACC_N_DEF,
  parameter int unsigned ROM_AW     = ROM_AW_DEF,
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  acc_seq_ctrl_if.master bus
);

  localparam int unsigned SW = cnt_w(SHIFT_N);
  localparam int unsigned AW = cnt_w(ACC_N);

  acc_state_e        state_q, state_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              load_en_q, alu_en_q, acc_finish_q, pready_q, busy_q;
  logic              wdt_fire_c;

  assign bus.load_en       = load_en_q;
  assign bus.ALU_en        = alu_en_q;
  assign bus.shift_counter = shift_q;
  assign bus.acc_counter   = acc_q;
  assign bus.rom_addr      = rom_addr_q;
  assign bus.acc_finish    = acc_finish_q;
  assign bus.pready        = pready_q;
  assign bus.busy          = busy_q;

`ifdef ACC_SEQ_WDT_EN
  logic wdt_expire_c;
  logic wdt_err_q;

  acc_seq_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q == ST_WAIT_WB),
    .expire_c_o (wdt_expire_c)
  );

  // A write-back arriving on the expiry cycle still wins.
  assign wdt_fire_c  = (state_q == ST_WAIT_WB) && !bus.cal_finish && wdt_expire_c;
  assign bus.wdt_err = wdt_err_q;
`else
  assign wdt_fire_c = 1'b0;
`endif

  // Next state and next counter values.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_in) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.load_done) begin
          state_d = ST_COMPUTE;
          shift_d = '0;
          acc_d   = '0;
        end
      end
      ST_COMPUTE: begin
        if (shift_q == SW'(SHIFT_N - 1)) state_d = ST_WAIT_WB;
        else                             shift_d = shift_q + SW'(1);
      end
      ST_WAIT_WB: begin
        if (bus.cal_finish) begin
          if (acc_q == AW'(ACC_N - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COMPUTE;
            acc_d   = acc_q + AW'(1);
            shift_d = '0;
          end
        end else if (wdt_fire_c) begin
          state_d = ST_IDLE;
          shift_d = '0;
          acc_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        shift_d = '0;
        acc_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = '0;
        acc_d   = '0;
      end
    endcase
    // Built from next-state counters so the address lines up with ALU_en.
    rom_addr_d = ROM_AW'(32'(acc_d) * SHIFT_N + 32'(shift_d));
  end

  // State, counters and Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      acc_q        <= '0;
      rom_addr_q   <= '0;
      load_en_q    <= 1'b0;
      alu_en_q     <= 1'b0;
      acc_finish_q <= 1'b0;
      pready_q     <= 1'b1;
      busy_q       <= 1'b0;
`ifdef ACC_SEQ_WDT_EN
      wdt_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      rom_addr_q   <= rom_addr_d;
      load_en_q    <= (state_d == ST_LOAD);
      alu_en_q     <= (state_d == ST_COMPUTE);
      acc_finish_q <= (state_d == ST_DONE);
      pready_q     <= !((state_d == ST_COMPUTE) || (state_d == ST_WAIT_WB));
      busy_q       <= (state_d != ST_IDLE);
`ifdef ACC_SEQ_WDT_EN
      wdt_err_q    <= wdt_fire_c;
`endif
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: self-checking bench for acc_seq_ctrl.
// Two instances: the default geometry (SHIFT_N=4, ACC_N=4) and a minimal
// one (SHIFT_N=2, ACC_N=1). Expected behaviour is derived from the job
// schedule (pass p, step s -> rom_addr p*SHIFT_N+s) rather than any state
// encoding. ACC_SEQ_WDT_EN additionally exercises the watchdog (WDT_CYCLES=8).
module tb_acc_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_sel = 1'b0;
  logic tb_start = 1'b0, tb_load = 1'b0, tb_cal = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_seq_ctrl_if #(.SHIFT_N(4), .ACC_N(4), .ROM_AW(4)) ifa ();
  acc_seq_ctrl_if #(.SHIFT_N(2), .ACC_N(1), .ROM_AW(2)) ifb ();

  acc_seq_ctrl #(.SHIFT_N(4), .ACC_N(4), .ROM_AW(4), .WDT_CYCLES(8)) u_dut (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  acc_seq_ctrl #(.SHIFT_N(2), .ACC_N(1), .ROM_AW(2), .WDT_CYCLES(8)) u_small (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  assign ifa.start_in   = tb_start & ~tb_sel;
  assign ifa.load_done  = tb_load  & ~tb_sel;
  assign ifa.cal_finish = tb_cal   & ~tb_sel;
  assign ifb.start_in   = tb_start & tb_sel;
  assign ifb.load_done  = tb_load  & tb_sel;
  assign ifb.cal_finish = tb_cal   & tb_sel;

  // Outputs of the instance currently under test.
  logic       obs_load_en, obs_alu, obs_fin, obs_pready, obs_busy, obs_wdt;
  logic [7:0] obs_shift, obs_acc, obs_rom;
  always_comb begin
    obs_load_en = tb_sel ? ifb.load_en    : ifa.load_en;
    obs_alu     = tb_sel ? ifb.ALU_en     : ifa.ALU_en;
    obs_fin     = tb_sel ? ifb.acc_finish : ifa.acc_finish;
    obs_pready  = tb_sel ? ifb.pready     : ifa.pready;
    obs_busy    = tb_sel ? ifb.busy       : ifa.busy;
    obs_shift   = tb_sel ? 8'(ifb.shift_counter) : 8'(ifa.shift_counter);
    obs_acc     = tb_sel ? 8'(ifb.acc_counter)   : 8'(ifa.acc_counter);
    obs_rom     = tb_sel ? 8'(ifb.rom_addr)      : 8'(ifa.rom_addr);
`ifdef ACC_SEQ_WDT_EN
    obs_wdt     = tb_sel ? ifb.wdt_err : ifa.wdt_err;
`else
    obs_wdt     = 1'b0;
`endif
  end

  // Event monitor: ALU cycles, completion pulses, stall-rule violations.
  int alu_cnt = 0, fin_cnt = 0, pr_bad = 0;
  int rom_q[$];
  int base_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (obs_alu) begin
        alu_cnt <= alu_cnt + 1;
        rom_q.push_back(int'(obs_rom));
      end
      if (obs_fin) fin_cnt <= fin_cnt + 1;
      if (!obs_pready && (obs_load_en || !obs_busy || obs_fin)) pr_bad <= pr_bad + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_load_en"}, 32'(obs_load_en), 0);
    chk({tag, "_alu_en"},  32'(obs_alu), 0);
    chk({tag, "_shift"},   32'(obs_shift), 0);
    chk({tag, "_acc"},     32'(obs_acc), 0);
    chk({tag, "_rom"},     32'(obs_rom), 0);
    chk({tag, "_fin"},     32'(obs_fin), 0);
    chk({tag, "_pready"},  32'(obs_pready), 1);
    chk({tag, "_busy"},    32'(obs_busy), 0);
    chk({tag, "_wdt"},     32'(obs_wdt), 0);
  endtask

  // One job: start, load_done ld_dly cycles later, cal_finish after cal_dly
  // wait cycles per pass (random 0..4 when negative). noise injects inputs
  // that must be ignored in the state they arrive in.
  task automatic run_job(input bit s, input int unsigned ld_dly, input int cal_dly,
                         input bit noise);
    int unsigned sn, an, w, alu0, fin0;
    sn = s ? 2 : 4;
    an = s ? 1 : 4;
    tb_sel = s;
    #0;
    rom_q.delete();
    alu0 = alu_cnt;
    fin0 = fin_cnt;
    chk("idle_busy", 32'(obs_busy), 0);
    chk("idle_pready", 32'(obs_pready), 1);
    tb_start = 1'b1; step(); tb_start = 1'b0;
    chk("load_en", 32'(obs_load_en), 1);
    chk("load_busy", 32'(obs_busy), 1);
    chk("load_pready", 32'(obs_pready), 1);
    for (int i = 1; i < int'(ld_dly); i++) begin
      if (noise && i == 1) tb_cal = 1'b1;
      step(); tb_cal = 1'b0;
      chk("load_hold", 32'(obs_load_en), 1);
      chk("load_alu", 32'(obs_alu), 0);
    end
    tb_load = 1'b1; step(); tb_load = 1'b0;
    for (int p = 0; p < int'(an); p++) begin
      for (int k = 0; k < int'(sn); k++) begin
        chk($sformatf("alu_en p%0d s%0d", p, k), 32'(obs_alu), 1);
        chk($sformatf("shift p%0d s%0d", p, k), 32'(obs_shift), 32'(k));
        chk($sformatf("acc p%0d s%0d", p, k), 32'(obs_acc), 32'(p));
        chk($sformatf("rom p%0d s%0d", p, k), 32'(obs_rom), 32'(p * int'(sn) + k));
        chk($sformatf("cmp_pready p%0d s%0d", p, k), 32'(obs_pready), 0);
        if (noise && k == 0) tb_start = 1'b1;
        if (noise && k == int'(sn) - 1) tb_cal = 1'b1;
        step(); tb_start = 1'b0; tb_cal = 1'b0;
      end
      w = (cal_dly < 0) ? $urandom_range(0, 4) : int'(cal_dly);
      chk($sformatf("wait_alu p%0d", p), 32'(obs_alu), 0);
      chk($sformatf("wait_pready p%0d", p), 32'(obs_pready), 0);
      chk($sformatf("wait_busy p%0d", p), 32'(obs_busy), 1);
      chk($sformatf("wait_fin p%0d", p), 32'(obs_fin), 0);
      for (int i = 0; i < int'(w); i++) begin
        if (noise && i == 0) tb_load = 1'b1;
        step(); tb_load = 1'b0;
        chk($sformatf("wait_hold_alu p%0d", p), 32'(obs_alu), 0);
        chk($sformatf("wait_hold_pready p%0d", p), 32'(obs_pready), 0);
      end
      tb_cal = 1'b1; step(); tb_cal = 1'b0;
    end
    chk("done_fin", 32'(obs_fin), 1);
    chk("done_pready", 32'(obs_pready), 1);
    chk("done_busy", 32'(obs_busy), 1);
    chk("done_alu", 32'(obs_alu), 0);
    step();
    chk("end_fin", 32'(obs_fin), 0);
    chk("end_busy", 32'(obs_busy), 0);
    chk("end_pready", 32'(obs_pready), 1);
    chk("end_load_en", 32'(obs_load_en), 0);
    chk("job_alu_cycles", 32'(alu_cnt - int'(alu0)), 32'(an * sn));
    chk("job_fin_pulses", 32'(fin_cnt - int'(fin0)), 1);
    chk("job_rom_count", 32'(rom_q.size()), 32'(an * sn));
  endtask

  initial begin
    // Power-on reset on both instances.
    rst = 1'b1;
    repeat (3) step();
    tb_sel = 1'b0; #0; chk_reset("por_a");
    tb_sel = 1'b1; #0; chk_reset("por_b");
    rst = 1'b0;
    tb_sel = 1'b0;
    step();

    // Reset held three cycles in the middle of COMPUTE.
    tb_start = 1'b1; step(); tb_start = 1'b0;
    step();
    tb_load = 1'b1; step(); tb_load = 1'b0;
    step(); step();
    chk("pre_rst_alu", 32'(obs_alu), 1);
    chk("pre_rst_shift", 32'(obs_shift), 2);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_reset("mid_rst");

    // Baseline job with the default geometry.
    run_job(1'b0, 5, 1, 1'b0);
    base_q = rom_q;

    // Same job with ignored start/cal/load pulses sprinkled in.
    run_job(1'b0, 5, 2, 1'b1);
    chk("noise_len", 32'(rom_q.size()), 32'(base_q.size()));
    for (int i = 0; i < base_q.size() && i < rom_q.size(); i++)
      chk($sformatf("noise_rom%0d", i), 32'(rom_q[i]), 32'(base_q[i]));

    // Minimal geometry: two ALU cycles, rom_addr 0,1.
    run_job(1'b1, 3, 1, 1'b0);
    chk("small_rom0", 32'(rom_q.size() > 0 ? rom_q[0] : -1), 0);
    chk("small_rom1", 32'(rom_q.size() > 1 ? rom_q[1] : -1), 1);

    // Randomized jobs across both instances.
    for (int j = 0; j < 6; j++)
      run_job(1'($urandom_range(0, 1)), $urandom_range(1, 6), -1, 1'b0);

`ifdef ACC_SEQ_WDT_EN
    // Write-back withheld: watchdog fires 8 cycles after WAIT_WB entry.
    begin
      int fin0;
      tb_sel = 1'b0;
      fin0 = fin_cnt;
      tb_start = 1'b1; step(); tb_start = 1'b0;
      tb_load = 1'b1; step(); tb_load = 1'b0;
      repeat (4) step();
      for (int i = 1; i < 8; i++) begin
        step();
        chk($sformatf("wdt_quiet%0d", i), 32'(obs_wdt), 0);
        chk($sformatf("wdt_busy%0d", i), 32'(obs_busy), 1);
      end
      step();
      chk("wdt_pulse", 32'(obs_wdt), 1);
      chk("wdt_idle", 32'(obs_busy), 0);
      chk("wdt_no_fin", 32'(obs_fin), 0);
      step();
      chk("wdt_pulse_end", 32'(obs_wdt), 0);
      chk("wdt_fin_count", 32'(fin_cnt - fin0), 0);
      run_job(1'b0, 2, 1, 1'b0);
    end
`endif

    chk("pready_rule", 32'(pr_bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
